// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage, MSB first, valid/ready on both sides.
// Optional feature macro: PARITY_EN (appends an even-parity bit after the LSB).
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last
);

`ifdef PARITY_EN
  localparam int unsigned N  = WIDTH + 1;
`else
  localparam int unsigned N  = WIDTH;
`endif
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    frame;
  logic            accept;
  logic            xfer;

  // Whole frame as it will leave the block, parity (if any) in the LSB slot.
  always_comb begin
    frame = '0;
`ifdef PARITY_EN
    frame = {load_data, ^load_data};
`else
    frame = load_data;
`endif
  end

  // Output decode straight from state; ser_out is the head of the shift register.
  assign ser_valid  = (state_q == SHIFT);
  assign ser_last   = ser_valid && (count_q == CW'(N - 1));
  assign ser_out    = shreg_q[N-1];
  assign load_ready = (state_q == IDLE) || (ser_last && ser_ready);
  assign accept     = load_valid && load_ready;
  assign xfer       = ser_valid && ser_ready;

  // Next-state: load, shift, reload on the last bit, or return to idle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = frame;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (ser_last) begin
            if (accept) begin
              shreg_d = frame;
              count_d = '0;
            end else begin
              state_d = IDLE;
              shreg_d = '0;
              count_d = '0;
            end
          end else begin
            shreg_d = {shreg_q[N-2:0], 1'b0};
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        count_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words expand into an expected
// bit queue; a monitor pops and compares on every serial transfer.
module tb_piso_serializer;

  localparam int unsigned WIDTH = 8;
`ifdef PARITY_EN
  localparam int unsigned N = WIDTH + 1;
`else
  localparam int unsigned N = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;

  int checks;
  int errors;

  // Expected stream: bit [1] = data bit, bit [0] = last flag.
  logic [1:0] exp_q[$];

  logic prev_stall;
  logic prev_out;
  logic prev_last;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_last   (ser_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference: a word becomes N bits, MSB first, optional even parity last.
  task automatic push_word(input logic [WIDTH-1:0] w);
    logic par;
    par = 1'b0;
    for (int i = 0; i < WIDTH; i++) par = par ^ w[i];
    for (int i = 0; i < int'(N); i++) begin
      logic b;
      if (i < int'(WIDTH)) b = w[WIDTH-1-i];
      else                 b = par;
      exp_q.push_back({b, (i == int'(N) - 1)});
    end
  endtask

  // Acceptance tracker: runs after the monitor, sees the handshake the next edge will take.
  always @(negedge clk) begin
    #1;
    if (rst) exp_q.delete();
    else if (load_valid && load_ready) push_word(load_data);
  end

  // Monitor: compare outputs against the model every cycle outside reset.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      logic [1:0] head;
      logic       exp_valid;
      exp_valid = (exp_q.size() != 0);
      chk("ser_valid", 32'(ser_valid), 32'(exp_valid));
      chk("load_ready", 32'(load_ready),
          32'((exp_q.size() == 0) || (exp_q.size() == 1 && ser_ready)));
      if (prev_stall) begin
        chk("stall_out", 32'(ser_out), 32'(prev_out));
        chk("stall_last", 32'(ser_last), 32'(prev_last));
      end
      if (exp_valid) begin
        head = exp_q[0];
        chk("ser_out", 32'(ser_out), 32'(head[1]));
        chk("ser_last", 32'(ser_last), 32'(head[0]));
        if (ser_valid && ser_ready) void'(exp_q.pop_front());
      end else begin
        chk("idle_out", 32'(ser_out), 32'd0);
        chk("idle_last", 32'(ser_last), 32'd0);
      end
      prev_stall = ser_valid && !ser_ready;
      prev_out   = ser_out;
      prev_last  = ser_last;
    end
  end

  task automatic drive(input logic lv, input logic [WIDTH-1:0] ld,
                       input logic sr, input logic r);
    @(posedge clk);
    #1;
    load_valid = lv;
    load_data  = ld;
    ser_ready  = sr;
    rst        = r;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, WIDTH'($urandom), 1'b1, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    prev_stall = 1'b0;
    prev_out   = 1'b0;
    prev_last  = 1'b0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    ser_ready  = 1'b0;

    // Reset then idle.
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("reset_load_ready", 32'(load_ready), 32'd1);
    chk("reset_ser_valid", 32'(ser_valid), 32'd0);
    chk("reset_ser_out", 32'(ser_out), 32'd0);
    chk("reset_ser_last", 32'(ser_last), 32'd0);
    idle_cycles(2);

    // Single frame 0xA5 at full rate.
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    idle_cycles(N + 2);

    // Stall for three cycles after bit 2 of 0xF0.
    drive(1'b1, 8'hF0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h55, 1'b0, 1'b0);
    idle_cycles(N + 2);

    // Back-to-back 0x81 then 0x7E with load_valid held high.
    drive(1'b1, 8'h81, 1'b1, 1'b0);
    for (int i = 0; i < int'(N); i++) drive(1'b1, 8'h7E, 1'b1, 1'b0);
    idle_cycles(N + 2);

    // Reset in the middle of 0xC3, then 0x3C.
    drive(1'b1, 8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    chk("midreset_ser_valid", 32'(ser_valid), 32'd0);
    chk("midreset_load_ready", 32'(load_ready), 32'd1);
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    idle_cycles(N + 2);

`ifdef PARITY_EN
    drive(1'b1, 8'h07, 1'b1, 1'b0);
    idle_cycles(N + 2);
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    idle_cycles(N + 2);
`endif

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 1) == 1),
            WIDTH'($urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 199) == 0));
    end

    // Drain and confirm nothing is left outstanding.
    idle_cycles(2 * N + 4);
    @(negedge clk);
    #2;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_ser_valid", 32'(ser_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
